// File: rtl/signal_window_fetch_if.sv
// Read-bank port and window stream of signal_window_fetch.
// Handshake: a window transfers on a rising Clk edge where out_valid && out_ready are both high;
// once out_valid rises, it and the whole window stay unchanged until that transfer.
// rd_data must be valid during the cycle after the one in which rd_en is high.
interface signal_window_fetch_if #(
  parameter int SIGNAL_bits = 16,
  parameter int ADDR_bits   = 19
);
  logic                        rd_en;
  logic [ADDR_bits-1:0]        rd_addr;
  logic [SIGNAL_bits-1:0]      rd_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [7:0][SIGNAL_bits-1:0] surrounding_signals;
  logic [7:0]                  border_mask;
  logic [SIGNAL_bits-1:0]      curSignal;
  logic [ADDR_bits-1:0]        writeLoc;

  modport master (
    output rd_en, rd_addr, out_valid, surrounding_signals, border_mask, curSignal, writeLoc,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, surrounding_signals, border_mask, curSignal, writeLoc,
    output rd_data, out_ready
  );
endinterface

// File: rtl/signal_window_fetch.sv
// Row-major 3x3 window fetch over the signal grid with a 3-column sliding window.
// Optional macro SIGNAL_WINDOW_BORDER_MIRROR_EN: out-of-grid neighbours replicate the centre value.
module signal_window_fetch #(
  parameter int GRID_W      = 640,
  parameter int GRID_H      = 480,
  parameter int SIGNAL_bits = 16,
  parameter int ADDR_bits   = $clog2(GRID_W*GRID_H)
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  output logic       busy,
  output logic       sweep_done,
  output logic [2:0] dbg_state,
  signal_window_fetch_if.master bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0]        X_LAST   = XW'(GRID_W - 1);
  localparam logic [YW-1:0]        Y_LAST   = YW'(GRID_H - 1);
  localparam logic [ADDR_bits-1:0] ROW_STEP = ADDR_bits'(GRID_W);
  localparam logic [ADDR_bits-1:0] ONE      = ADDR_bits'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_ROW = 3'd1,
    LOAD_COL = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                 state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [ADDR_bits-1:0]   cell_addr;
  logic [1:0]             ld_slot, ld_row;
  logic                   cap_en;
  logic [1:0]             cap_slot, cap_row;
  // win[column slot][row]: slot 0/1/2 = x-1/x/x+1, row 0/1/2 = y-1/y/y+1
  logic [SIGNAL_bits-1:0] win     [3][3];
  logic [SIGNAL_bits-1:0] win_nxt [3][3];
  logic [SIGNAL_bits-1:0] fill_val;
  logic [7:0]             mask_now;
  logic                   top, bot, lft, rgt;

  assign dbg_state = state;

  function automatic logic [1:0] first_row(input logic [YW-1:0] yy);
    return (yy == '0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] last_row(input logic [YW-1:0] yy);
    return (yy == Y_LAST) ? 2'd1 : 2'd2;
  endfunction

  // Only in-grid neighbours are ever read, so modular address arithmetic is exact.
  function automatic logic [ADDR_bits-1:0] nb_addr(input logic [ADDR_bits-1:0] base,
                                                   input logic [1:0] slot,
                                                   input logic [1:0] row);
    logic [ADDR_bits-1:0] a;
    a = base;
    if (row == 2'd0)      a = a - ROW_STEP;
    else if (row == 2'd2) a = a + ROW_STEP;
    if (slot == 2'd2)      a = a + ONE;
    else if (slot == 2'd0) a = a - ONE;
    return a;
  endfunction

  // The final read of a load lands on the same edge that enters EMIT.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        win_nxt[c][r] = win[c][r];
      end
    end
    if (cap_en) win_nxt[cap_slot][cap_row] = bus.rd_data;
  end

  always_comb begin
    top      = (y == '0);
    bot      = (y == Y_LAST);
    lft      = (x == '0);
    rgt      = (x == X_LAST);
    mask_now = {bot | rgt, bot, bot | lft, rgt, lft, top | rgt, top, top | lft};
`ifdef SIGNAL_WINDOW_BORDER_MIRROR_EN
    fill_val = win_nxt[1][1];
`else
    fill_val = '0;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state                   <= IDLE;
      x                       <= '0;
      y                       <= '0;
      cell_addr               <= '0;
      ld_slot                 <= '0;
      ld_row                  <= '0;
      cap_en                  <= 1'b0;
      cap_slot                <= '0;
      cap_row                 <= '0;
      busy                    <= 1'b0;
      sweep_done              <= 1'b0;
      bus.rd_en               <= 1'b0;
      bus.rd_addr             <= '0;
      bus.out_valid           <= 1'b0;
      bus.surrounding_signals <= '0;
      bus.border_mask         <= '0;
      bus.curSignal           <= '0;
      bus.writeLoc            <= '0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win[c][r] <= '0;
        end
      end
    end else begin
      sweep_done <= 1'b0;
      cap_en     <= bus.rd_en;
      cap_slot   <= ld_slot;
      cap_row    <= ld_row;
      win        <= win_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            x           <= '0;
            y           <= '0;
            cell_addr   <= '0;
            state       <= LOAD_ROW;
            // Column x-1 is off-grid at row start, so the scan begins at slot 1.
            ld_slot     <= 2'd1;
            ld_row      <= first_row('0);
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= nb_addr('0, 2'd1, first_row('0));
          end
        end
        LOAD_ROW, LOAD_COL: begin
          if (bus.rd_en) begin
            if (ld_row != last_row(y)) begin
              ld_row      <= ld_row + 2'd1;
              bus.rd_addr <= nb_addr(cell_addr, ld_slot, ld_row + 2'd1);
            end else if (state == LOAD_ROW && ld_slot == 2'd1) begin
              ld_slot     <= 2'd2;
              ld_row      <= first_row(y);
              bus.rd_addr <= nb_addr(cell_addr, 2'd2, first_row(y));
            end else begin
              bus.rd_en <= 1'b0;
            end
          end else begin
            state                      <= EMIT;
            bus.out_valid              <= 1'b1;
            bus.writeLoc               <= cell_addr;
            bus.border_mask            <= mask_now;
            bus.curSignal              <= win_nxt[1][1];
            bus.surrounding_signals[0] <= mask_now[0] ? fill_val : win_nxt[0][0];
            bus.surrounding_signals[1] <= mask_now[1] ? fill_val : win_nxt[1][0];
            bus.surrounding_signals[2] <= mask_now[2] ? fill_val : win_nxt[2][0];
            bus.surrounding_signals[3] <= mask_now[3] ? fill_val : win_nxt[0][1];
            bus.surrounding_signals[4] <= mask_now[4] ? fill_val : win_nxt[2][1];
            bus.surrounding_signals[5] <= mask_now[5] ? fill_val : win_nxt[0][2];
            bus.surrounding_signals[6] <= mask_now[6] ? fill_val : win_nxt[1][2];
            bus.surrounding_signals[7] <= mask_now[7] ? fill_val : win_nxt[2][2];
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (x != X_LAST) begin
              x         <= x + XW'(1);
              cell_addr <= cell_addr + ONE;
              state     <= LOAD_COL;
              ld_slot   <= 2'd2;
              ld_row    <= first_row(y);
              for (int r = 0; r < 3; r++) begin
                win[0][r] <= win[1][r];
                win[1][r] <= win[2][r];
              end
              // The new right-hand column is off-grid for the last cell of a row.
              bus.rd_en <= ((x + XW'(1)) != X_LAST);
              if ((x + XW'(1)) != X_LAST)
                bus.rd_addr <= nb_addr(cell_addr + ONE, 2'd2, first_row(y));
            end else if (y != Y_LAST) begin
              x           <= '0;
              y           <= y + YW'(1);
              cell_addr   <= cell_addr + ONE;
              state       <= LOAD_ROW;
              ld_slot     <= 2'd1;
              ld_row      <= 2'd0;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= nb_addr(cell_addr + ONE, 2'd1, 2'd0);
            end else begin
              state      <= DONE;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_signal_window_fetch.sv
// Directed bench for signal_window_fetch on a 4x3 grid holding cell(x,y) = 16*y + x.
module tb_signal_window_fetch;
  localparam int GW = 4;
  localparam int GH = 3;
  localparam int SB = 16;
  localparam int AB = $clog2(GW*GH);
  localparam int NC = GW*GH;

  typedef struct {
    logic [AB-1:0]        loc;
    logic [7:0]           mask;
    logic [SB-1:0]        cur;
    logic [7:0][SB-1:0]   nb;
  } win_t;

  logic       Clk;
  logic       Reset_n;
  logic       start;
  logic       busy;
  logic       sweep_done;
  logic [2:0] dbg_state;

  signal_window_fetch_if #(.SIGNAL_bits(SB), .ADDR_bits(AB)) bus ();

  signal_window_fetch #(.GRID_W(GW), .GRID_H(GH), .SIGNAL_bits(SB), .ADDR_bits(AB)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .busy       (busy),
    .sweep_done (sweep_done),
    .dbg_state  (dbg_state),
    .bus        (bus.master)
  );

  win_t tbl  [NC];
  win_t seen [NC];
  int   dx_tab [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int   dy_tab [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  int   n_cmp, n_bad, xfers, dones, reads, lat_cnt;
  bit   lat_on, hold_pend, stall_mode;
  logic [AB-1:0]      max_addr;
  logic               pend_en;
  logic [AB-1:0]      pend_addr;
  logic [7:0][SB-1:0] snap_nb;
  logic [7:0]         snap_mask;
  logic [SB-1:0]      snap_cur;
  logic [AB-1:0]      snap_loc;

  function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Read bank: data valid the cycle after rd_en
  always @(negedge Clk) begin
    pend_en   = bus.rd_en;
    pend_addr = bus.rd_addr;
  end

  always @(posedge Clk) begin
    #1;
    if (pend_en) bus.rd_data = SB'(16 * (int'(pend_addr) / GW) + int'(pend_addr) % GW);
    else         bus.rd_data = 16'hDEAD;
    bus.out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard / monitor
  always @(negedge Clk) begin
    if (!Reset_n) begin
      hold_pend = 1'b0;
      lat_on    = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_nb", bus.surrounding_signals, snap_nb);
        chk("hold_misc", {bus.border_mask, bus.curSignal, bus.writeLoc},
            {snap_mask, snap_cur, snap_loc});
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      snap_nb   = bus.surrounding_signals;
      snap_mask = bus.border_mask;
      snap_cur  = bus.curSignal;
      snap_loc  = bus.writeLoc;
      if (lat_on) begin
        lat_cnt++;
        if (bus.out_valid) begin
          lat_on = 1'b0;
          if (int'(tbl[xfers].loc) % GW != 0) chk("col_latency", lat_cnt <= 5, 1);
          else                                chk("row_latency", lat_cnt <= 11, 1);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (xfers < NC) begin
          chk("win_nb", bus.surrounding_signals, tbl[xfers].nb);
          chk("win_mask", bus.border_mask, tbl[xfers].mask);
          chk("win_cur", bus.curSignal, tbl[xfers].cur);
          chk("win_loc", bus.writeLoc, tbl[xfers].loc);
          seen[xfers].nb   = bus.surrounding_signals;
          seen[xfers].mask = bus.border_mask;
          seen[xfers].cur  = bus.curSignal;
          seen[xfers].loc  = bus.writeLoc;
        end else begin
          chk("extra_xfer", xfers, NC - 1);
        end
        xfers++;
        lat_on  = (xfers < NC);
        lat_cnt = 0;
      end
      if (sweep_done) begin
        dones++;
        chk("done_after_last", xfers, NC);
      end
      if (bus.rd_en) begin
        reads++;
        if (bus.rd_addr > max_addr) max_addr = bus.rd_addr;
      end
    end
  end

  // Driver tasks
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_nb"}, bus.surrounding_signals, 0);
    chk({tag, "_mask"}, bus.border_mask, 0);
    chk({tag, "_cur"}, bus.curSignal, 0);
    chk({tag, "_loc"}, bus.writeLoc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, sweep_done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic run_sweep(input bit stall, input bit extra_start);
    int cyc;
    stall_mode = stall;
    xfers      = 0;
    dones      = 0;
    reads      = 0;
    max_addr   = '0;
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc <= 12) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("first_latency", cyc <= 10, 1);
    if (extra_start) begin
      #2 start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
    end
    cyc = 0;
    while (dones == 0 && cyc < 600) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("sweep_finished", dones > 0, 1);
    repeat (4) @(posedge Clk);
    #1;
    chk("xfer_count", xfers, NC);
    chk("done_count", dones, 1);
    chk("read_count", reads, 28);
    chk("addr_in_grid", max_addr < NC, 1);
    chk("busy_after", busy, 0);
    stall_mode = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        int  i, nx, ny;
        bit  outside;
        i = y * GW + x;
        tbl[i].loc = AB'(i);
        tbl[i].cur = SB'(16 * y + x);
        for (int d = 0; d < 8; d++) begin
          nx = x + dx_tab[d];
          ny = y + dy_tab[d];
          outside = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
          tbl[i].mask[d] = outside;
`ifdef SIGNAL_WINDOW_BORDER_MIRROR_EN
          tbl[i].nb[d] = outside ? tbl[i].cur : SB'(16 * ny + nx);
`else
          tbl[i].nb[d] = outside ? '0 : SB'(16 * ny + nx);
`endif
        end
      end
    end

    n_cmp = 0; n_bad = 0; xfers = 0; dones = 0; reads = 0;
    stall_mode = 1'b0; max_addr = '0;
    Reset_n = 1'b0; start = 1'b0;
    bus.out_ready = 1'b1; bus.rd_data = '0;
    #12;
    check_reset_outputs("reset");
    #10 Reset_n = 1'b1;

    // Sweep with out_ready held high
    run_sweep(1'b0, 1'b0);
    chk("c11_nb", seen[5].nb,
        {16'd34, 16'd33, 16'd32, 16'd18, 16'd16, 16'd2, 16'd1, 16'd0});
    chk("c11_cur", seen[5].cur, 17);
    chk("c11_loc", seen[5].loc, 5);
    chk("c11_mask", seen[5].mask, 8'h00);
    chk("c00_mask", seen[0].mask, 8'h2F);
    chk("c00_nb", seen[0].nb,
        {16'd17, 16'd16, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0});

    // Random stalls plus a start pulse while busy
    run_sweep(1'b1, 1'b1);

    // Reset during LOAD_COL of cell (2,1)
    xfers = 0; dones = 0;
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    cyc = 0;
    while (xfers < 6 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    chk("abort_reached", xfers, 6);
    @(posedge Clk); #2;
    chk("abort_state", dbg_state, 2);
    chk("abort_reading", bus.rd_en, 1);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge Clk);
    #1;
    chk("abort_no_done", dones, 0);
    #2 Reset_n = 1'b1;

    run_sweep(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/signal_window_fetch.md
# signal_window_fetch

Streams the pheromone-signal grid out of the read bank in row-major order and presents, for each cell, its centre value and 8 neighbours to the downstream next-signal calculator. It sits directly upstream of the next-signal combinational stage: it owns the grid scan, the read-memory interface and the border handling, and hands out one cell per valid/ready transfer. A 3-column sliding window means each interior cell costs 3 memory reads instead of 9.

## Interface
- GRID_W, 640: grid width in cells (≥2).
- GRID_H, 480: grid height in cells (≥2).
- SIGNAL_bits, 16: signal value width.
- ADDR_bits, $clog2(GRID_W*GRID_H): cell address width.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins one full sweep; ignored while busy.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_bits  read address, y*GRID_W+x.
- rd_data  in  SIGNAL_bits  read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  window for current cell is valid.
- out_ready  in  1  downstream accepts the window.
- surrounding_signals  out  8×SIGNAL_bits  neighbours d=0..7: NW,N,NE,W,E,SW,S,SE.
- border_mask  out  8  bit d set = neighbour d lies outside the grid.
- curSignal  out  SIGNAL_bits  centre cell value.
- writeLoc  out  ADDR_bits  centre cell address.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after the last cell is accepted.

## Operation
- States: IDLE, LOAD_ROW (fill 3 columns x-1..x+1), LOAD_COL (fill column x+1), EMIT, DONE.
- IDLE: start → x=0, y=0, busy=1, LOAD_ROW.
- Column load: rows y-1, y, y+1 in that order, one rd_en per cycle, back-to-back; rows outside 0..GRID_H-1 issue no read and fill the border value. Columns outside 0..GRID_W-1 are never read and fill entirely with the border value.
- LOAD_ROW loads columns x-1, x, x+1 (x=0 at row start) → EMIT.
- EMIT: out_valid=1, outputs stable until out_ready. On the transfer: x<GRID_W-1 → window shifts left one column, x++, LOAD_COL; x=GRID_W-1 and y<GRID_H-1 → x=0, y++, LOAD_ROW; last cell → DONE.
- LOAD_COL loads column x+1 → EMIT.
- DONE: sweep_done=1 for one cycle, busy=0 → IDLE.
- border_mask is derived from (x,y) only: row 0 sets NW,N,NE; row GRID_H-1 sets SW,S,SE; col 0 sets NW,W,SW; col GRID_W-1 sets NE,E,SE. Corner cells set 5 bits.
- No arithmetic is performed on signal values; values pass through unmodified.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, surrounding_signals=0, border_mask=0, curSignal=0, writeLoc=0, busy=0, sweep_done=0; state IDLE.
- Reset mid-sweep aborts immediately; no sweep_done; in-flight read data is discarded.
- rd_en/rd_addr registered; data captured on the cycle after rd_en.
- First out_valid for cell (0,0): cycle 3·3+1 after the start cycle at the latest (9 read slots, minus skipped out-of-grid reads, plus capture).
- Interior mid-row cell: out_valid ≤4 cycles after the previous transfer.
- out_valid never deasserts without a transfer; no reads are issued while in EMIT.
- start coincident with DONE is ignored.

## Configuration
- SIGNAL_WINDOW_BORDER_MIRROR_EN defined: out-of-grid neighbours are filled with the centre cell's value (border replicates curSignal); border_mask still reports them.
- Undefined: out-of-grid neighbours are filled with 0.

## Test plan
- 4×3 grid, cell(x,y)=16·y+x, out_ready=1, start → 12 windows in row-major order; cell (1,1): surrounding = {0,1,2,16,18,32,33,34}, curSignal=17, writeLoc=5, border_mask=0x00.
- Same grid, cell (0,0) → border_mask=0x2F (NW,N,NE,W,SW), in-grid E=1, S=16, SE=17; out-of-grid = 0, or 0 with SIGNAL_WINDOW_BORDER_MIRROR_EN.
- Random out_ready stalls → outputs held stable while out_valid && !out_ready; exactly 12 transfers; sweep_done single pulse after the 12th.
- Count rd_en over a 4×3 sweep → each in-grid cell read once per window load it falls in; no rd_addr ≥ 12 ever issued.
- Reset_n low during LOAD_COL of cell (2,1) → all outputs return to reset values asynchronously; new start yields a full, correct sweep.
- start pulsed while busy → ignored; exactly one sweep_done.
